deserializer: RTL and testbench
===============================

DESERIALIZER -- requirements
Module: deserializer

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning deserialized word width; the port widths below apply at the default value.
REQ-002 SHALL have port clk_i  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port srst_i  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port data_i  input  1  serial data bit; sampled only when data_val_i=1.
REQ-005 SHALL have port data_val_i  input  1  qualifies data_i for the current cycle.
REQ-006 SHALL have port deser_data_o  output  16 (DATA_W)  assembled parallel word.
REQ-007 SHALL have port deser_data_val_o  output  1  one-cycle strobe marking a new deser_data_o.

Function
REQ-008 SHALL, on each rising clk_i edge with data_val_i=1, capture data_i into an internal shift register and increment a bit counter (0..DATA_W-1).
REQ-009 SHALL ignore data_i and leave the shift register and counter unchanged on any cycle with data_val_i=0; gaps of any length between valid bits SHALL be allowed.
REQ-010 SHALL use MSB-first ordering: the first valid bit of a word SHALL appear at deser_data_o[15], and the 16th valid bit at deser_data_o[0].
REQ-011 SHALL, on the edge that captures the 16th valid bit (counter = DATA_W-1), register the complete word into deser_data_o and set deser_data_val_o=1 for exactly one cycle.
REQ-012 SHALL wrap the counter to 0 on that same edge, so the next valid bit starts a new word with no dead cycle.
REQ-013 SHALL give a latency of 1 cycle: deser_data_val_o is high in the cycle after the clock edge that sampled the 16th valid bit.
REQ-014 SHALL hold deser_data_o stable at the last completed word until the next word completes.
REQ-015 SHALL drive deser_data_val_o to 0 on every cycle other than the one following word completion.
REQ-016 SHALL allow back-to-back words (32 consecutive valid cycles) to produce strobes exactly 16 cycles apart.
REQ-017 SHALL discard a partial word, without emitting a strobe, when srst_i is asserted mid-word; counting SHALL restart from bit 0 after release.
REQ-018 SHALL treat X/unknown data_i as don't-care when data_val_i=0.

Reset
REQ-019 SHALL, while srst_i=1 and independent of clk_i, force deser_data_o=16'h0000, deser_data_val_o=0, the bit counter to 0 and the shift register to 0.
REQ-020 SHALL sample the first valid bit on the first rising edge after srst_i deasserts.

Verification
REQ-021 SHALL pass this test: pulse srst_i with data_val_i=0 held -> deser_data_o=16'h0000 and deser_data_val_o=0 for all cycles.
REQ-022 SHALL pass this test: 16 consecutive valid bits 1,0,1,0,... (first bit 1) -> one strobe with deser_data_o=16'hAAAA, in the cycle after the 16th bit.
REQ-023 SHALL pass this test: the same 16 bits of 16'hC3A5 with random data_val_i gaps (1-5 idle cycles, data_i random when idle) -> a single strobe with 16'hC3A5; no strobe during the gaps.
REQ-024 SHALL pass this test: 32 consecutive valid bits forming 16'h1234 then 16'hFFFF -> strobes exactly 16 cycles apart, carrying 16'h1234 then 16'hFFFF; deser_data_o holds 16'hFFFF afterwards.
REQ-025 SHALL pass this test: 10 valid bits, then assert srst_i asynchronously (between edges), then 16 valid bits of 16'h0F0F -> no strobe for the partial word; outputs go to 0 immediately on reset; one strobe with 16'h0F0F follows.
REQ-026 SHALL pass this test: 1000 cycles of random data_i/data_val_i checked against a reference model -> strobe count = floor(valid bits/16), and each word matches MSB-first packing.

Source files
------------

// File: rtl/deserializer.sv
// Serial-to-parallel converter: packs DATA_W qualified serial bits MSB-first
// into a word and pulses a one-cycle strobe when each word completes.
module deserializer #(
  parameter int DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              data_i,
  input  logic              data_val_i,
  output logic [DATA_W-1:0] deser_data_o,
  output logic              deser_data_val_o
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] next_shift;

  // Earlier bits move toward the MSB, so the first bit of a word lands in bit DATA_W-1.
  assign next_shift = {shift_reg[DATA_W-2:0], data_i};

  // NOTE: all state here is sequential and uses non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      bit_cnt          <= '0;
      shift_reg        <= '0;
      deser_data_o     <= '0;
      deser_data_val_o <= 1'b0;
    end else begin
      deser_data_val_o <= 1'b0;
      if (data_val_i) begin
        shift_reg <= next_shift;
        if (bit_cnt == LAST_BIT) begin
          // Word complete: publish it and wrap so the next valid bit starts a new word.
          bit_cnt          <= '0;
          deser_data_o     <= next_shift;
          deser_data_val_o <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_deserializer.sv
// Randomized self-checking bench for deserializer: a queue-based model predicts
// the strobe and output word every cycle, plus directed word/reset scenarios.
module tb_deserializer;

  localparam int DATA_W = 16;

  logic              clk_i = 1'b0;
  logic              srst_i = 1'b1;
  logic              data_i = 1'b0;
  logic              data_val_i = 1'b0;
  logic [DATA_W-1:0] deser_data_o;
  logic              deser_data_val_o;

  deserializer #(.DATA_W(DATA_W)) dut (
    .clk_i            (clk_i),
    .srst_i           (srst_i),
    .data_i           (data_i),
    .data_val_i       (data_val_i),
    .deser_data_o     (deser_data_o),
    .deser_data_val_o (deser_data_val_o)
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Reference model: pending bits of the current word, and the predicted outputs.
  int          bit_q[$];
  logic        exp_val = 1'b0;
  logic [31:0] exp_word = '0;

  // Strobes seen from the DUT, for per-scenario checks.
  logic [31:0] obs_words[$];
  int          obs_cyc[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    bit_q.delete();
    exp_val  = 1'b0;
    exp_word = '0;
  endtask

  task automatic model_edge(input logic d, input logic v);
    exp_val = 1'b0;
    if (v) begin
      bit_q.push_back(int'(d));
      if (bit_q.size() == DATA_W) begin
        exp_word = '0;
        for (int i = 0; i < DATA_W; i++)
          if (bit_q[i] != 0) exp_word = exp_word + (32'd1 << (DATA_W - 1 - i));
        exp_val = 1'b1;
        bit_q.delete();
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".val"}, 32'(deser_data_val_o), 32'(exp_val));
    check({tag, ".data"}, 32'(deser_data_o), exp_word);
  endtask

  task automatic step(input logic d, input logic v);
    data_i     = d;
    data_val_i = v;
    @(posedge clk_i);
    model_edge(d, v);
    #1;
    check_outputs("step");
    if (deser_data_val_o) begin
      obs_words.push_back(32'(deser_data_o));
      obs_cyc.push_back(cyc);
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'($urandom), 1'b0);
  endtask

  task automatic send_word(input logic [DATA_W-1:0] w, input bit gaps);
    for (int i = DATA_W - 1; i >= 0; i--) begin
      if (gaps) idle(int'($urandom_range(1, 5)));
      step(w[i], 1'b1);
    end
  endtask

  task automatic do_reset();
    data_val_i = 1'b0;
    srst_i = 1'b1;
    model_reset();
    #1;
    check_outputs("rst_async");
    for (int i = 0; i < 2; i++) begin
      @(posedge clk_i);
      #1;
      check_outputs("rst_hold");
      cyc++;
    end
    srst_i = 1'b0;
  endtask

  initial begin
    int valid_bits;
    logic [DATA_W-1:0] w;

    // Power-on reset, then a reset pulse with data_val_i held low.
    @(posedge clk_i);
    #1;
    check_outputs("por");
    srst_i = 1'b0;
    idle(3);
    do_reset();
    idle(5);
    check("idle.strobes", 32'(obs_words.size()), 32'd0);

    // Alternating pattern, consecutive valid bits.
    obs_words.delete(); obs_cyc.delete();
    w = 16'hAAAA;
    send_word(w, 1'b0);
    idle(2);
    check("aaaa.count", 32'(obs_words.size()), 32'd1);
    if (obs_words.size() > 0) check("aaaa.word", obs_words[0], 32'h0000_AAAA);

    // Same word shape with random idle gaps between bits.
    obs_words.delete(); obs_cyc.delete();
    send_word(16'hC3A5, 1'b1);
    idle(3);
    check("gaps.count", 32'(obs_words.size()), 32'd1);
    if (obs_words.size() > 0) check("gaps.word", obs_words[0], 32'h0000_C3A5);

    // Back-to-back words: strobes exactly DATA_W cycles apart.
    obs_words.delete(); obs_cyc.delete();
    send_word(16'h1234, 1'b0);
    send_word(16'hFFFF, 1'b0);
    idle(4);
    check("b2b.count", 32'(obs_words.size()), 32'd2);
    if (obs_words.size() == 2) begin
      check("b2b.spacing", 32'(obs_cyc[1] - obs_cyc[0]), 32'd16);
      check("b2b.word0", obs_words[0], 32'h0000_1234);
      check("b2b.word1", obs_words[1], 32'h0000_FFFF);
    end
    check("b2b.hold", 32'(deser_data_o), 32'h0000_FFFF);

    // Partial word discarded by an asynchronous reset between edges.
    obs_words.delete(); obs_cyc.delete();
    for (int i = 0; i < 10; i++) step(1'($urandom), 1'b1);
    #2;
    do_reset();
    check("abort.data_zero", 32'(deser_data_o), 32'd0);
    send_word(16'h0F0F, 1'b0);
    idle(2);
    check("abort.count", 32'(obs_words.size()), 32'd1);
    if (obs_words.size() > 0) check("abort.word", obs_words[0], 32'h0000_0F0F);

    // Long random run against the model.
    do_reset();
    obs_words.delete(); obs_cyc.delete();
    valid_bits = 0;
    for (int i = 0; i < 1000; i++) begin
      logic v;
      v = ($urandom_range(0, 3) != 0);
      if (v) valid_bits++;
      step(1'($urandom), v);
    end
    idle(2);
    check("rand.count", 32'(obs_words.size()), 32'(valid_bits / DATA_W));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
